// File: rtl/rf_pkg.sv
// Shared widths and FSM encoding for the operand fetch stage and its
// pending-write scoreboard.
package rf_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A set and a clear of the same bit in one cycle leaves the bit set.
module rf_scoreboard #(
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W,
    parameter int unsigned NREG   = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    output logic [NREG-1:0]   busy
);

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
    end

    // Set is applied after clear so it wins on a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= (busy & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: accepts one decoded instruction at a time, waits for
// both source registers to be free of pending writes, captures operands
// (bypassing same-cycle write-back) and hands them to execute.
module operand_fetch_unit #(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [ADDR_W-1:0] dec_rs,
    input  logic [ADDR_W-1:0] dec_rt,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic              dec_wr,
    output logic [ADDR_W-1:0] rdReg1,
    output logic [ADDR_W-1:0] rdReg2,
    input  logic [DATA_W-1:0] rdData1,
    input  logic [DATA_W-1:0] rdData2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_wr
);
    import rf_pkg::*;

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    state_t state, state_nx;

    logic                rst_done;
    logic [ADDR_W-1:0]   lat_rs, lat_rt, lat_rd;
    logic                lat_wr;
    logic [NUM_REGS-1:0] busy;
    logic                byp_a, byp_b, both_rdy;
    logic                accept, capture, handshake;

    assign byp_a    = wb_en && (wb_reg == lat_rs);
    assign byp_b    = wb_en && (wb_reg == lat_rt);
    assign both_rdy = (!busy[lat_rs] || byp_a) && (!busy[lat_rt] || byp_b);

    // Read addresses come straight from the latched fields, which only
    // change on accept, so they hold their last value while idle.
    assign rdReg1 = lat_rs;
    assign rdReg2 = lat_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nx;
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (rst_done && dec_valid) state_nx = ST_READ;
            ST_READ: if (both_rdy)              state_nx = ST_HOLD;
            ST_HOLD: if (ex_ready)              state_nx = ST_IDLE;
            default:                            state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        dec_ready = 1'b0;
        ex_valid  = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            ST_IDLE: begin
                dec_ready = rst_done;
                accept    = rst_done && dec_valid;
            end
            ST_READ: capture = both_rdy;
            ST_HOLD: begin
                ex_valid  = 1'b1;
                handshake = ex_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rs <= '0;
            lat_rt <= '0;
            lat_rd <= '0;
            lat_wr <= 1'b0;
            ex_opA <= '0;
            ex_opB <= '0;
            ex_rd  <= '0;
            ex_wr  <= 1'b0;
        end else begin
            if (accept) begin
                lat_rs <= dec_rs;
                lat_rt <= dec_rt;
                lat_rd <= dec_rd;
                lat_wr <= dec_wr;
            end
            if (capture) begin
                ex_opA <= byp_a ? wb_data : rdData1;
                ex_opB <= byp_b ? wb_data : rdData2;
                ex_rd  <= lat_rd;
                ex_wr  <= lat_wr;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NUM_REGS)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (handshake && ex_wr),
        .set_idx (ex_rd),
        .clr_en  (wb_en),
        .clr_idx (wb_reg),
        .busy    (busy)
    );

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: behavioural register file, expected-result
// queue filled at issue and drained at the execute handshake.
module tb_operand_fetch_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dec_valid = 1'b0;
    logic          dec_ready;
    logic [AW-1:0] dec_rs = '0, dec_rt = '0, dec_rd = '0;
    logic          dec_wr = 1'b0;
    logic [AW-1:0] rdReg1, rdReg2;
    logic [DW-1:0] rdData1, rdData2;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_reg = '0;
    logic [DW-1:0] wb_data = '0;
    logic          ex_valid;
    logic          ex_ready = 1'b0;
    logic [DW-1:0] ex_opA, ex_opB;
    logic [AW-1:0] ex_rd;
    logic          ex_wr;

    logic [DW-1:0] rf [32];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          wr;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic          wr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    assign rdData1 = rf[rdReg1];
    assign rdData2 = rf[rdReg2];

    operand_fetch_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_rs    (dec_rs),
        .dec_rt    (dec_rt),
        .dec_rd    (dec_rd),
        .dec_wr    (dec_wr),
        .rdReg1    (rdReg1),
        .rdReg2    (rdReg2),
        .rdData1   (rdData1),
        .rdData2   (rdData2),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_opA    (ex_opA),
        .ex_opB    (ex_opB),
        .ex_rd     (ex_rd),
        .ex_wr     (ex_wr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic rf_init();
        for (int i = 0; i < 32; i++) rf[i] = 32'hA0 + 32'(i);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] rd, input logic wr,
                         input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        int n = 0;
        while (dec_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_dec_ready", 32'(dec_ready), 32'd1);
        dec_valid = 1'b1;
        dec_rs = rs;
        dec_rt = rt;
        dec_rd = rd;
        dec_wr = wr;
        sb_q.push_back('{ea, eb, rd, wr});
        @(negedge clk);
        dec_valid = 1'b0;
    endtask

    task automatic collect(input logic wb_hs, input logic [AW-1:0] wreg, input logic [DW-1:0] wdata);
        exp_t e;
        int n = 0;
        while (ex_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ex_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout ex_valid actual=%b required=1", ex_valid);
            return;
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL collect_unexpected queue_size actual=0 required>0");
            return;
        end
        e = sb_q.pop_front();
        check("ex_opA", ex_opA, e.a);
        check("ex_opB", ex_opB, e.b);
        check("ex_rd", 32'(ex_rd), 32'(e.rd));
        check("ex_wr", 32'(ex_wr), 32'(e.wr));
        ex_ready = 1'b1;
        if (wb_hs) begin
            wb_en = 1'b1;
            wb_reg = wreg;
            wb_data = wdata;
        end
        @(negedge clk);
        ex_ready = 1'b0;
        if (wb_hs) begin
            wb_en = 1'b0;
            rf[wreg] = wdata;
        end
    endtask

    task automatic writeback(input logic [AW-1:0] wreg, input logic [DW-1:0] wdata);
        wb_en = 1'b1;
        wb_reg = wreg;
        wb_data = wdata;
        @(negedge clk);
        wb_en = 1'b0;
        rf[wreg] = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rf_init();

        // Reset state
        #2;
        check("rst_dec_ready", 32'(dec_ready), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_rdReg1", 32'(rdReg1), 32'd0);
        check("rst_ex_opA", ex_opA, 32'd0);
        check("rst_busy", dut.u_sb.busy, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_dec_ready", 32'(dec_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_dec_ready", 32'(dec_ready), 32'd1);

        // Basic latency: valid on the second edge after acceptance
        rf[1] = 32'd2;
        rf[3] = 32'd2;
        issue(5'd1, 5'd3, 5'd5, 1'b0, 32'd2, 32'd2);
        check("lat_ex_valid_edge1", 32'(ex_valid), 32'd0);
        check("lat_dec_ready_read", 32'(dec_ready), 32'd0);
        check("lat_rdReg1", 32'(rdReg1), 32'd1);
        check("lat_rdReg2", 32'(rdReg2), 32'd3);
        @(negedge clk);
        check("lat_ex_valid_edge2", 32'(ex_valid), 32'd1);
        check("lat_dec_ready_hold", 32'(dec_ready), 32'd0);
        collect(1'b0, '0, '0);

        // Table of hazard-free instructions
        rf_init();
        vecs[0] = '{5'd2,  5'd7,  5'd9,  1'b0, 32'hA2, 32'hA7};
        vecs[1] = '{5'd0,  5'd31, 5'd1,  1'b0, 32'hA0, 32'hBF};
        vecs[2] = '{5'd15, 5'd15, 5'd3,  1'b0, 32'hAF, 32'hAF};
        vecs[3] = '{5'd30, 5'd1,  5'd0,  1'b0, 32'hBE, 32'hA1};
        vecs[4] = '{5'd8,  5'd20, 5'd17, 1'b0, 32'hA8, 32'hB4};
        vecs[5] = '{5'd31, 5'd16, 5'd31, 1'b1, 32'hBF, 32'hB0};
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].b);
            collect(1'b0, '0, '0);
        end
        check("table_busy31", dut.u_sb.busy, 32'h8000_0000);
        writeback(5'd31, 32'hDEAD);
        check("table_busy_clear", dut.u_sb.busy, 32'd0);

        // RAW stall resolved by same-cycle write-back bypass
        issue(5'd1, 5'd2, 5'd4, 1'b1, 32'hA1, 32'hA2);
        collect(1'b0, '0, '0);
        check("raw_busy4_set", 32'(dut.u_sb.busy[4]), 32'd1);
        issue(5'd4, 5'd2, 5'd6, 1'b0, 32'h55, 32'hA2);
        for (int i = 0; i < 3; i++) begin
            check("raw_stall_ex_valid", 32'(ex_valid), 32'd0);
            check("raw_stall_dec_ready", 32'(dec_ready), 32'd0);
            @(negedge clk);
        end
        wb_en = 1'b1;
        wb_reg = 5'd4;
        wb_data = 32'h55;
        @(negedge clk);
        wb_en = 1'b0;
        rf[4] = 32'h55;
        check("raw_bypass_ex_valid", 32'(ex_valid), 32'd1);
        check("raw_busy4_clear", 32'(dut.u_sb.busy[4]), 32'd0);
        collect(1'b0, '0, '0);

        // Set and clear of the same bit at once: set wins
        issue(5'd7, 5'd8, 5'd4, 1'b1, 32'hA7, 32'hA8);
        collect(1'b0, '0, '0);
        issue(5'd9, 5'd10, 5'd4, 1'b1, 32'hA9, 32'hAA);
        collect(1'b1, 5'd4, 32'h66);
        check("set_wins_busy4", 32'(dut.u_sb.busy[4]), 32'd1);
        writeback(5'd4, 32'h77);
        check("set_wins_then_clear", dut.u_sb.busy, 32'd0);

        // Back-pressure in HOLD; a new dec_valid must not be taken
        issue(5'd3, 5'd5, 5'd12, 1'b1, 32'hA3, 32'hA5);
        @(negedge clk);
        dec_valid = 1'b1;
        dec_rs = 5'd0;
        dec_rt = 5'd0;
        dec_rd = 5'd1;
        for (int i = 0; i < 5; i++) begin
            check("hold_ex_valid", 32'(ex_valid), 32'd1);
            check("hold_ex_opA", ex_opA, 32'hA3);
            check("hold_ex_opB", ex_opB, 32'hA5);
            check("hold_ex_rd", 32'(ex_rd), 32'd12);
            check("hold_dec_ready", 32'(dec_ready), 32'd0);
            @(negedge clk);
        end
        dec_valid = 1'b0;
        collect(1'b0, '0, '0);
        check("hold_busy12", dut.u_sb.busy, 32'h0000_1000);

        // Reset during a READ stall
        issue(5'd6, 5'd12, 5'd4, 1'b1, 32'hA6, 32'hAC);
        for (int i = 0; i < 2; i++) begin
            check("rst_stall_ex_valid", 32'(ex_valid), 32'd0);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("midrst_ex_valid", 32'(ex_valid), 32'd0);
        check("midrst_busy", dut.u_sb.busy, 32'd0);
        check("midrst_dec_ready", 32'(dec_ready), 32'd0);
        check("midrst_rdReg1", 32'(rdReg1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_dec_ready", 32'(dec_ready), 32'd1);
        check("midrst_release_ex_valid", 32'(ex_valid), 32'd0);

        // Register 0 is bypassed like any other, rs == rt
        issue(5'd0, 5'd0, 5'd2, 1'b0, 32'd7, 32'd7);
        wb_en = 1'b1;
        wb_reg = 5'd0;
        wb_data = 32'd7;
        @(negedge clk);
        wb_en = 1'b0;
        rf[0] = 32'd7;
        collect(1'b0, '0, '0);

        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (2**ADDR_W registers).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dec_valid  input  1  decode stage presents an instruction.
REQ-006 SHALL have port dec_ready  output  1  unit accepts the instruction this cycle.
REQ-007 SHALL have ports dec_rs, dec_rt, dec_rd  input  ADDR_W each  source 1, source 2 and destination indices.
REQ-008 SHALL have port dec_wr  input  1  instruction writes dec_rd.
REQ-009 SHALL have ports rdReg1, rdReg2  output  ADDR_W each  register-file read addresses.
REQ-010 SHALL have ports rdData1, rdData2  input  DATA_W each  register-file read data, combinational from the addresses.
REQ-011 SHALL have ports wb_en, wb_reg, wb_data  input  1/ADDR_W/DATA_W  write-back into the register file this cycle.
REQ-012 SHALL have ports ex_valid, ex_ready  output/input  1 each  execute-stage handshake.
REQ-013 SHALL have ports ex_opA, ex_opB  output  DATA_W each  captured operands.
REQ-014 SHALL have ports ex_rd, ex_wr  output  ADDR_W/1  forwarded destination and write flag.

Function
REQ-015 SHALL implement FSM IDLE, READ, HOLD.
REQ-016 IDLE: dec_ready=1; on dec_valid latch rs, rt, rd, wr and go to READ.
REQ-017 READ/HOLD: dec_ready=0; at most one instruction in flight.
REQ-018 rdReg1/rdReg2 SHALL drive the latched rs/rt in READ and HOLD, and hold their last value in IDLE.
REQ-019 SHALL keep a NREG-bit pending-write scoreboard; bit r set means a write to r is issued but not written back.
REQ-020 Operand rs is ready in READ when its scoreboard bit is clear, or when wb_en=1 and wb_reg=rs in the same cycle; the same rule applies to rt.
REQ-021 READ with both operands ready: capture and go to HOLD; otherwise stay in READ (stall, no capture).
REQ-022 Capture SHALL take wb_data when wb_en=1 and wb_reg matches the index, else rdData; this applies per operand independently.
REQ-023 HOLD: ex_valid=1 and ex_opA/ex_opB/ex_rd/ex_wr stable until ex_ready=1, then go to IDLE.
REQ-024 Latency without hazard: accepted at edge N, capture at edge N+1, ex_valid high after N+1; the minimum issue interval is 3 cycles.
REQ-025 Scoreboard bit ex_rd SHALL set at the HOLD handshake when ex_wr=1.
REQ-026 Scoreboard bit wb_reg SHALL clear when wb_en=1; a clear of an already-clear bit is a no-op.
REQ-027 A set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-028 Register 0 SHALL receive no special treatment; it is tracked and bypassed like any register.
REQ-029 dec_rs=dec_rt SHALL be legal, and both operands SHALL receive the same value.

Reset
REQ-030 rst_n low SHALL force IDLE, scoreboard all-zero, ex_valid=0, ex_opA=ex_opB=0, ex_rd=0, ex_wr=0, rdReg1=rdReg2=0, and latched fields to 0.
REQ-031 dec_ready SHALL be 0 while rst_n is low and 1 from the first edge after release.
REQ-032 Reset asserted mid-operation (READ stall or HOLD) SHALL drop the in-flight instruction without any scoreboard update.

Structure
REQ-033 A shared package rf_pkg SHALL hold DATA_W, ADDR_W, NREG and the FSM state enum.
REQ-034 The scoreboard SHALL be one sub-module, rf_scoreboard, with ports set_en, set_idx, clr_en, clr_idx, busy[NREG-1:0].
REQ-035 The write-back port is observed only and is never driven by this unit.

Verification
REQ-036 Reset then dec_valid with rs=1, rt=3, register file holding 2 and 2 -> ex_valid on the 2nd edge, opA=2, opB=2, dec_ready=0 until the handshake.
REQ-037 Issue rd=4, wr=1, then an instruction reading rs=4 with no write-back -> stays in READ and ex_valid stays 0; wb_en=1, wb_reg=4, wb_data=0x55 -> opA=0x55 captured in that cycle and the bit clears.
REQ-038 Scoreboard bit 4 set with no hazard, and wb_en, wb_reg=4 coinciding with a new handshake ex_rd=4, ex_wr=1 -> bit 4 remains set.
REQ-039 ex_ready held 0 for 5 cycles in HOLD -> ex_opA/ex_opB/ex_rd unchanged and dec_ready=0 throughout.
REQ-040 rst_n pulsed low during a READ stall -> immediate IDLE, ex_valid=0, scoreboard=0, dec_ready=1 after release.
REQ-041 rs=rt=0 with wb_en, wb_reg=0, wb_data=7 in the capture cycle -> opA=opB=7.
